// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types for the regfile write-back front end
// Purpose: write-back request payload, source tag and width constants.
// Ports:   none (package).
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - issue/ALU/LSU/regfile-write bundle of the write-back arbiter
// Purpose: groups every bus signal of regfile_wb_arbiter.
// Ports:   issue_* (pending marking), alu_* and lsu_* result handshakes,
//          rd_* regfile write port, pending_o scoreboard.
//          slave modport = arbiter side, master modport = environment side.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
);

  logic                          issue_valid_i;
  logic [regfile_pkg::REG_AW-1:0] issue_rd_i;
  logic                          alu_valid_i;
  logic                          alu_ready_o;
  logic [regfile_pkg::REG_AW-1:0] alu_rd_i;
  logic [XLEN-1:0]               alu_data_i;
  logic                          lsu_valid_i;
  logic                          lsu_ready_o;
  logic [regfile_pkg::REG_AW-1:0] lsu_rd_i;
  logic [XLEN-1:0]               lsu_data_i;
  logic                          rd_wren_o;
  logic [regfile_pkg::REG_AW-1:0] rd_addr_o;
  logic [XLEN-1:0]               rd_data_o;
  logic [NREG-1:0]               pending_o;

  modport slave (
    input  issue_valid_i, issue_rd_i,
    input  alu_valid_i, alu_rd_i, alu_data_i,
    output alu_ready_o,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o,
    output rd_wren_o, rd_addr_o, rd_data_o, pending_o
  );

  modport master (
    output issue_valid_i, issue_rd_i,
    output alu_valid_i, alu_rd_i, alu_data_i,
    input  alu_ready_o,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o,
    input  rd_wren_o, rd_addr_o, rd_data_o, pending_o
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// rtl/regfile_wb_arbiter_wb_fifo.sv - synchronous FIFO of write-back requests
// Purpose: in-order buffer for LSU results, no bypass from push to pop.
// Ports:   clk_i, rst_ni (async, active low), push_i/push_data_i,
//          pop_i/pop_data_o (head), full_o, empty_o, count_o.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_req_t          push_data_i,
  input  logic             pop_i,
  output wb_req_t          pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Guarded on the registered state so a pop never frees room for a same-cycle push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges ALU and LSU results into the single regfile write port
// Purpose: arbitration with bounded LSU starvation, registered write port,
//          pending-load scoreboard for issue stalls.
// Ports:   clk_i, rst_ni (async, active low), bus (slave modport):
//          issue_*, alu_* / lsu_* handshakes, rd_wren/addr/data_o, pending_o.
module regfile_wb_arbiter
  import regfile_pkg::wb_req_t;
  import regfile_pkg::wb_src_t;
  import regfile_pkg::SRC_ALU;
  import regfile_pkg::SRC_LSU;
  import regfile_pkg::REG_AW;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  wb_req_t          push_req, head_req;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push, fifo_pop;
  logic             alu_ready, lsu_ready, alu_win;

  logic              wren_q, wren_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  wb_src_t           src_q, src_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic [NREG-1:0]   pending_q, pending_d;

  assign push_req = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_req),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Both readies are held low while reset is asserted.
  assign lsu_ready = rst_ni && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign alu_ready = rst_ni && !(!fifo_empty && (starve_q == ST_W'(STARVE_LIMIT)));
  assign alu_win   = bus.alu_valid_i && alu_ready;

  // x0 loads complete the handshake but are dropped here.
  assign fifo_push = bus.lsu_valid_i && lsu_ready && !fifo_full && (bus.lsu_rd_i != '0);
  assign fifo_pop  = rst_ni && !alu_win && !fifo_empty;

  always_comb begin
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    if (alu_win) begin
      src_d = SRC_ALU;
      if (bus.alu_rd_i != '0) begin
        wren_d = 1'b1;
        addr_d = bus.alu_rd_i;
        data_d = bus.alu_data_i;
      end
    end else if (fifo_pop) begin
      src_d  = SRC_LSU;
      wren_d = 1'b1;
      addr_d = head_req.rd;
      data_d = head_req.data;
    end
  end

  // A non-empty FIFO that is not popped has necessarily lost to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != ST_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  // Clear on the edge ending the LSU write cycle; a same-edge issue re-sets the bit.
  always_comb begin
    pending_d = pending_q;
    if (wren_q && (src_q == SRC_LSU)) pending_d[addr_q] = 1'b0;
    if (bus.issue_valid_i && (bus.issue_rd_i != '0)) pending_d[bus.issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= SRC_ALU;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;
  assign bus.rd_wren_o   = wren_q;
  assign bus.rd_addr_o   = addr_q;
  assign bus.rd_data_o   = data_q;
  assign bus.pending_o   = pending_q;

endmodule
